// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - serial-to-parallel word receiver with a one-deep valid/ready output buffer
// Optional parity bit after each word: define PARITY_CHECK_EN.
module serial_deserializer #(
   parameter int WIDTH  = 4,
   parameter int PARITY = 0
) (
   input  logic             CLK,
   input  logic             CLEAR_N,
   input  logic             s_valid,
   input  logic             s_start,
   input  logic             s_in,
   input  logic             s_dir,
   output logic [WIDTH-1:0] p_output,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             busy,
   output logic             overrun,
   input  logic             err_clr,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sh;
   logic             r_dir;
   logic [WIDTH-1:0] r_out;
   logic             r_valid;
   logic             r_busy;
   logic             r_overrun;
   logic             r_perr;

   logic [WIDTH-1:0] w_first;
   logic [WIDTH-1:0] w_shifted;
   logic             w_last;
   logic             w_done;
   logic [WIDTH-1:0] w_word;
   logic             w_perr;
   logic             w_can_load;

   assign w_first   = s_dir ? {s_in, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, s_in};
   assign w_shifted = r_dir ? {s_in, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], s_in};
   assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));

`ifdef PARITY_CHECK_EN
   assign w_done = s_valid & ~s_start & (r_state == PAR);
   assign w_word = r_sh;
   assign w_perr = (^{r_sh, s_in}) != 1'(PARITY);
`else
   // The completing bit is folded in combinationally so the buffer loads on the same edge.
   assign w_done = s_valid & ~s_start & w_last;
   assign w_word = w_shifted;
   assign w_perr = 1'b0;
   logic w_unused_parity;
   assign w_unused_parity = (PARITY != 0);
`endif

   assign w_can_load = ~r_valid | p_ready;

   always_ff @(posedge CLK or negedge CLEAR_N) begin
      if (!CLEAR_N) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sh      <= '0;
         r_dir     <= 1'b0;
         r_out     <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_perr    <= 1'b0;
      end else begin
         if (s_valid) begin
            if (s_start) begin
               r_state <= SHIFT;
               r_busy  <= 1'b1;
               r_cnt   <= CW'(1);
               r_sh    <= w_first;
               r_dir   <= s_dir;
            end else begin
               case (r_state)
                  SHIFT: begin
                     r_sh  <= w_shifted;
                     r_cnt <= r_cnt + 1'b1;
                     if (w_last) begin
`ifdef PARITY_CHECK_EN
                        r_state <= PAR;
`else
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
`endif
                     end
                  end
                  PAR: begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_cnt   <= '0;
                  end
                  default: ;
               endcase
            end
         end

         if (err_clr) begin
            r_overrun <= 1'b0;
            r_perr    <= 1'b0;
         end
         // A dropped word must set overrun even when err_clr is asserted in the same cycle.
         if (w_done) begin
            if (w_can_load) begin
               r_out   <= w_word;
               r_valid <= 1'b1;
               r_perr  <= w_perr;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && p_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign p_output   = r_out;
   assign p_valid    = r_valid;
   assign busy       = r_busy;
   assign overrun    = r_overrun;
   assign parity_err = r_perr;

endmodule
